// File: rtl/cmp_pkg.sv
// Shared types and helpers for the chunked compare scheduler: FSM states,
// the one-hot lt/eq/gt result, default widths and the signed-to-offset flip.
package cmp_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CHUNK_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_res_t;

    // Inverting the MSB maps two's-complement order onto unsigned order.
    function automatic logic [XLEN_DEF-1:0] to_offset(input logic [XLEN_DEF-1:0] op,
                                                      input logic                sgn);
        to_offset = {op[XLEN_DEF-1] ^ sgn, op[XLEN_DEF-2:0]};
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned magnitude compare of one CHUNK-wide operand slice.
module cmp_chunk
    import cmp_pkg::*;
#(
    parameter int W = CHUNK_DEF
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output cmp_res_t     o_res
);

    // Exactly one flag is raised for any operand pair.
    always_comb begin
        o_res = '0;
        if (i_a < i_b) begin
            o_res.lt = 1'b1;
        end else if (i_a > i_b) begin
            o_res.gt = 1'b1;
        end else begin
            o_res.eq = 1'b1;
        end
    end

endmodule

// File: rtl/cmp_sched_checker.sv
// Protocol and response-shape properties for cmp_sched, attached alongside the design.
module cmp_sched_checker (
    input logic       clk,
    input logic       rst_n,
    input logic [1:0] req_valid,
    input logic [1:0] req_ready,
    input logic [1:0] rsp_valid,
    input logic       rsp_lt,
    input logic       rsp_eq,
    input logic       rsp_gt
);

    for (genvar p = 0; p < 2; p++) begin : g_hold
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[p] && !req_ready[p]) |=> req_valid[p])
            else $error("cmp_sched_checker: req_valid[%0d] dropped before req_ready", p);
    end

    a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid != 2'b00) |-> ($onehot(rsp_valid) && $onehot({rsp_lt, rsp_eq, rsp_gt})))
        else $error("cmp_sched_checker: response not one-hot");

    a_rsp_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid == 2'b00) |-> ({rsp_lt, rsp_eq, rsp_gt} == 3'b000))
        else $error("cmp_sched_checker: result flags without rsp_valid");

endmodule

// File: rtl/cmp_sched.sv
// Two-port round-robin compare scheduler scanning operands MSB-first one chunk
// per cycle. Define CMP_SCHED_EARLY_EXIT_EN to stop scanning at the first differing chunk.
module cmp_sched
    import cmp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    input  logic [1:0][XLEN-1:0] req_a,
    input  logic [1:0][XLEN-1:0] req_b,
    input  logic [1:0]           req_signed,
    output logic [1:0]           req_ready,
    output logic [1:0]           rsp_valid,
    output logic                 rsp_lt,
    output logic                 rsp_eq,
    output logic                 rsp_gt,
    output logic                 busy
);

    localparam int NBEAT = XLEN / CHUNK;
    localparam int IDXW  = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    cmp_state_e      r_state;
    logic            r_last_grant;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic            r_id;
    logic [IDXW-1:0] r_idx;
    cmp_res_t        r_res;
    logic            r_decided;
    logic [1:0]      r_rsp_valid;
    cmp_res_t        r_rsp;
    logic            r_busy;

    logic            w_grant_id;
    logic            w_take;
    logic [XLEN-1:0] w_off_a;
    logic [XLEN-1:0] w_off_b;
    logic [CHUNK-1:0] w_chunk_a;
    logic [CHUNK-1:0] w_chunk_b;
    cmp_res_t        w_chunk_res;
    cmp_res_t        w_final;
    logic            w_mismatch;
    logic            w_early_stop;
    logic            w_last;

    // Arbiter: a lone requester wins; on a tie the port not granted last time wins.
    always_comb begin
        w_grant_id = 1'b0;
        case (req_valid)
            2'b01:   w_grant_id = 1'b0;
            2'b10:   w_grant_id = 1'b1;
            2'b11:   w_grant_id = ~r_last_grant;
            default: w_grant_id = 1'b0;
        endcase
    end

    assign w_take = (r_state == IDLE) && (req_valid != 2'b00);

    // Acceptance pulse is combinational so the requester sees it in the grant cycle.
    always_comb begin
        req_ready = 2'b00;
        if (w_take) begin
            req_ready = w_grant_id ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    if (XLEN == XLEN_DEF) begin : g_pkg_flip
        assign w_off_a = to_offset(req_a[w_grant_id], req_signed[w_grant_id]);
        assign w_off_b = to_offset(req_b[w_grant_id], req_signed[w_grant_id]);
    end else begin : g_wide_flip
        assign w_off_a = {req_a[w_grant_id][XLEN-1] ^ req_signed[w_grant_id],
                          req_a[w_grant_id][XLEN-2:0]};
        assign w_off_b = {req_b[w_grant_id][XLEN-1] ^ req_signed[w_grant_id],
                          req_b[w_grant_id][XLEN-2:0]};
    end

    assign w_chunk_a = r_op_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_chunk_b = r_op_b[int'(r_idx) * CHUNK +: CHUNK];

    cmp_chunk #(
        .W (CHUNK)
    ) u_chunk (
        .i_a   (w_chunk_a),
        .i_b   (w_chunk_b),
        .o_res (w_chunk_res)
    );

    assign w_mismatch = ~w_chunk_res.eq;
    // A result decided on an earlier chunk takes priority over lower chunks.
    assign w_final    = r_decided ? r_res : w_chunk_res;

`ifdef CMP_SCHED_EARLY_EXIT_EN
    assign w_early_stop = w_mismatch;
`else
    assign w_early_stop = 1'b0;
`endif

    assign w_last = (r_idx == IDXW'(0)) || w_early_stop;

    // Scheduler FSM with operand, index and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_id         <= 1'b0;
            r_idx        <= '0;
            r_res        <= '0;
            r_decided    <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp        <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rsp_valid <= 2'b00;
                    r_rsp       <= '0;
                    if (w_take) begin
                        r_op_a       <= w_off_a;
                        r_op_b       <= w_off_b;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_idx        <= IDXW'(NBEAT - 1);
                        r_res        <= '0;
                        r_decided    <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= SCAN;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_last) begin
                        r_rsp_valid <= r_id ? 2'b10 : 2'b01;
                        r_rsp       <= w_final;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                        if (!r_decided && w_mismatch) begin
                            r_res     <= w_chunk_res;
                            r_decided <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_rsp_valid <= 2'b00;
                    r_rsp       <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_rsp       <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_lt    = r_rsp.lt;
    assign rsp_eq    = r_rsp.eq;
    assign rsp_gt    = r_rsp.gt;
    assign busy      = r_busy;

endmodule

// File: tb/tb_cmp_sched.sv
// Directed and random self-checking bench for cmp_sched; expected latency follows
// the CMP_SCHED_EARLY_EXIT_EN build setting.
module tb_cmp_sched;

    localparam int NBEAT = 4;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       req_signed;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic             rsp_lt;
    logic             rsp_eq;
    logic             rsp_gt;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    cmp_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_lt     (rsp_lt),
        .rsp_eq     (rsp_eq),
        .rsp_gt     (rsp_gt),
        .busy       (busy)
    );

    cmp_sched_checker u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq),
        .rsp_gt    (rsp_gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result as {lt,eq,gt}.
    function automatic logic [2:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        if (s ? ($signed(a) < $signed(b)) : (a < b)) return 3'b100;
        else if (a == b) return 3'b010;
        else return 3'b001;
    endfunction

    // Cycles from handshake to rsp_valid.
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] fa;
        logic [31:0] fb;
        int          lat;
        fa  = {a[31] ^ s, a[30:0]};
        fb  = {b[31] ^ s, b[30:0]};
        lat = NBEAT + 1;
        for (int k = 0; k < NBEAT; k++) begin
            if (lat == NBEAT + 1 && fa[(NBEAT-1-k)*8 +: 8] != fb[(NBEAT-1-k)*8 +: 8]) lat = k + 2;
        end
`ifdef CMP_SCHED_EARLY_EXIT_EN
        return lat;
`else
        return (lat > 0) ? NBEAT + 1 : 0;
`endif
    endfunction

    task automatic wait_ready(input int p, output int ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[p] === 1'b1) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic wait_rsp(output int lat, output logic [1:0] rv, output logic [2:0] fl,
                            output logic b1);
        lat = 0; rv = 2'b00; fl = 3'b000; b1 = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) b1 = busy;
            if (rsp_valid !== 2'b00) begin
                lat = c;
                rv  = rsp_valid;
                fl  = {rsp_lt, rsp_eq, rsp_gt};
                return;
            end
        end
    endtask

    task automatic run_req(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input string tag);
        int         ok;
        int         lat;
        logic [1:0] rv;
        logic [2:0] fl;
        logic       b1;
        @(posedge clk); #1;
        req_a[p] = a; req_b[p] = b; req_signed[p] = s; req_valid[p] = 1'b1;
        wait_ready(p, ok);
        chk({tag, " grant"}, 64'(ok), 64'd1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        wait_rsp(lat, rv, fl, b1);
        chk({tag, " busy"}, 64'(b1), 64'd1);
        chk({tag, " port"}, 64'(rv), 64'(2'b01 << p));
        chk({tag, " result"}, 64'(fl), 64'(ref_res(a, b, s)));
        chk({tag, " latency"}, 64'(lat), 64'(ref_lat(a, b, s)));
        @(negedge clk);
        chk({tag, " idle after"}, 64'({busy, rsp_valid}), 64'd0);
    endtask

    initial begin
        int         gcyc[4];
        int         gport[4];
        int         rcyc[4];
        int         rport[4];
        logic [2:0] rfl[4];
        int         ng;
        int         nr;
        int         ok;
        int         lat;
        int         seen;
        logic [1:0] rv;
        logic [2:0] fl;
        logic       b1;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          rp;
        int          sel;

        rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_signed = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset outputs", 64'({req_ready, rsp_valid, rsp_lt, rsp_eq, rsp_gt, busy}), 64'd0);

        run_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "p0 signed -1<1");
        run_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "p1 unsigned gt");
        run_req(1, 32'h1234_5678, 32'h1234_5678, 1'b0, "p1 equal");
        run_req(0, 32'h8000_0000, 32'h0000_0000, 1'b0, "msb gt");
        run_req(1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "signed max>min");
        run_req(0, 32'h1234_5600, 32'h1234_56FF, 1'b0, "lsb chunk lt");

        // Both ports held valid from reset: strict alternation, 6 cycles apart.
        rst_n = 1'b0;
        req_a[0] = 32'd5; req_b[0] = 32'd3; req_signed[0] = 1'b0;
        req_a[1] = 32'd1; req_b[1] = 32'd9; req_signed[1] = 1'b0;
        req_valid = 2'b11;
        @(posedge clk); #1 rst_n = 1'b1;
        ng = 0; nr = 0;
        for (int i = 0; i < 4; i++) begin
            gcyc[i] = -1; gport[i] = -1; rcyc[i] = -1; rport[i] = -1; rfl[i] = 3'b000;
        end
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00 && ng < 4) begin
                gcyc[ng] = c; gport[ng] = (req_ready == 2'b10) ? 1 : 0; ng++;
            end
            if (rsp_valid != 2'b00 && nr < 4) begin
                rcyc[nr] = c; rport[nr] = (rsp_valid == 2'b10) ? 1 : 0;
                rfl[nr] = {rsp_lt, rsp_eq, rsp_gt}; nr++;
            end
        end
        chk("rr grant count", 64'(ng), 64'd4);
        chk("rr rsp count", 64'(nr), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rr grant port", 64'(gport[i]), 64'(i % 2));
            chk("rr grant cycle", 64'(gcyc[i]), 64'(6 * i));
            chk("rr rsp port", 64'(rport[i]), 64'(i % 2));
            chk("rr rsp cycle", 64'(rcyc[i]), 64'(6 * i + 5));
            chk("rr rsp flags", 64'(rfl[i]), (i % 2 == 0) ? 64'(3'b001) : 64'(3'b100));
        end
        rst_n = 1'b0;
        req_valid = 2'b00;
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset during the second SCAN cycle drops the compare.
        @(posedge clk); #1;
        req_a[1] = 32'hAAAA_5555; req_b[1] = 32'hAAAA_5555; req_signed[1] = 1'b0;
        req_valid[1] = 1'b1;
        wait_ready(1, ok);
        chk("mid-scan grant", 64'(ok), 64'd1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", 64'({req_ready, rsp_valid, rsp_lt, rsp_eq, rsp_gt, busy}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen = 1;
        end
        chk("no rsp after reset", 64'(seen), 64'd0);

        // First tie after reset goes to port 0, then port 1 is served.
        @(posedge clk); #1;
        req_a[0] = 32'd7;          req_b[0] = 32'd7;          req_signed[0] = 1'b0;
        req_a[1] = 32'hFFFF_FFFF;  req_b[1] = 32'h0000_0000;  req_signed[1] = 1'b1;
        req_valid = 2'b11;
        wait_ready(0, ok);
        chk("tie grant seen", 64'(ok), 64'd1);
        chk("tie ready one-hot p0", 64'(req_ready), 64'(2'b01));
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_rsp(lat, rv, fl, b1);
        chk("tie p0 port", 64'(rv), 64'(2'b01));
        chk("tie p0 result", 64'(fl), 64'(3'b010));
        chk("tie p0 latency", 64'(lat), 64'd5);
        wait_ready(1, ok);
        chk("tie p1 grant", 64'(ok), 64'd1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_rsp(lat, rv, fl, b1);
        chk("tie p1 port", 64'(rv), 64'(2'b10));
        chk("tie p1 result", 64'(fl), 64'(3'b100));
        chk("tie p1 latency", 64'(lat), 64'(ref_lat(32'hFFFF_FFFF, 32'h0, 1'b1)));

        // Random mix: 40% equal, 20% single-chunk difference, rest independent.
        for (int n = 0; n < 3000; n++) begin
            rp  = int'($urandom_range(1, 0));
            rs  = 1'($urandom_range(1, 0));
            ra  = $urandom;
            sel = int'($urandom_range(99, 0));
            if (sel < 40) rb = ra;
            else if (sel < 60) rb = ra ^ (32'($urandom_range(255, 1)) << (8 * $urandom_range(3, 0)));
            else rb = $urandom;
            run_req(rp, ra, rb, rs, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
